ifetch: RTL

Instruction fetch unit: the initiator side of the instruction-memory read port. Holds the word-addressed program counter, drives `imem_addr`, captures `imem_readdata` in the same cycle (imem reads combinationally) and buffers fetched words in a small prefetch queue. The queue is presented to decode through a valid/ready handshake. A redirect port, used for branches and jumps, flushes the queue and restarts fetch at a new address.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_fifo.sv | 62 ++++++
 rtl/ifetch.sv | 88 ++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// HALT_INSN is only compared when the design is built with IFETCH_HALT_EN.
package ifetch_pkg;

    localparam int IFETCH_N = 32;
    localparam int IFETCH_R = 6;

    localparam logic [IFETCH_N-1:0] HALT_INSN = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [IFETCH_R-1:0] pc;
        logic [IFETCH_N-1:0] insn;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO: push, pop, flush; head is read from registered storage.
// A push while full is accepted only together with a pop of the same slot.
module ifetch_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Empty queue reads as zero so the head is defined right after reset.
    assign dout = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_ok) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, imem addressing, prefetch queue and redirect.
// Build option IFETCH_HALT_EN stops fetching after a HALT_INSN word is enqueued.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int             n          = 32,
    parameter int             r          = 6,
    parameter int             DEPTH      = 4,
    parameter logic [r-1:0]   RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [r-1:0]  imem_addr,
    input  logic [n-1:0]  imem_readdata,
    output logic [n-1:0]  instr,
    output logic [r-1:0]  instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          redirect_valid,
    input  logic [r-1:0]  redirect_addr,
    output logic          halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [r-1:0]   pc;
    logic [r+n-1:0] head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           pop;
    logic           push;

    assign imem_addr   = pc;
    assign instr_valid = !fifo_empty;
    assign instr       = head[n-1:0];
    assign instr_pc    = head[r+n-1:n];

    // A full queue can still take a word when decode frees the head this cycle.
    assign pop  = instr_valid && instr_ready;
    assign push = !halted && !redirect_valid && (!fifo_full || pop);

    ifetch_fifo #(
        .W     (r + n),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .din   ({pc, imem_readdata}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_ADDR;
        end else if (redirect_valid) begin
            pc <= redirect_addr;
        end else if (push) begin
            pc <= pc + r'(1);
        end
    end

`ifdef IFETCH_HALT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            halted <= 1'b0;
        end else if (push && imem_readdata == n'(HALT_INSN)) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

    // Occupancy bound and full flag must agree with the count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (fifo_count <= CW'(DEPTH) && fifo_full == (fifo_count == CW'(DEPTH)));
        end
    end

endmodule
